// File: rtl/soc_rst_sequencer_pkg.sv
// soc_rst_sequencer_pkg: state/cause encodings and parameter defaults shared by the reset sequencer
package soc_rst_sequencer_pkg;
  localparam logic [1:0] ST_HOLD       = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK  = 2'd1;
  localparam logic [1:0] ST_REL_PERIPH = 2'd2;
  localparam logic [1:0] ST_RUN        = 2'd3;
  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_LOCK = 2'd2;
  localparam logic [1:0] CAUSE_SW   = 2'd3;
  localparam int unsigned DEF_MIN_HOLD    = 16;
  localparam int unsigned DEF_LOCK_CYCLES = 1024;
  localparam int unsigned DEF_GAP_CYCLES  = 16;
  localparam int unsigned DEF_DEB_CYCLES  = 4096;
endpackage

// File: rtl/soc_rst_sequencer_sync2.sv
// sync2: two-flop synchronizer, cleared to 0 by asynchronous active-low reset
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/soc_rst_sequencer.sv
// soc_rst_sequencer: staged peripheral/core reset release gated on PLL lock, with debounced button, lock-loss and software aborts
module soc_rst_sequencer
  import soc_rst_sequencer_pkg::*;
#(
  parameter int unsigned MIN_HOLD    = DEF_MIN_HOLD,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
  parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ext_rst_n_i,
  input  logic       pll_locked_i,
  input  logic       sw_rst_req_i,
  output logic       periph_rst_n_o,
  output logic       core_rst_n_o,
  output logic [1:0] seq_state_o,
  output logic [1:0] rst_cause_o
);
  localparam logic [15:0] HOLD_LAST = 16'(MIN_HOLD - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCK_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] DEB_MAX   = 16'(DEB_CYCLES);
  logic        btn_s, lock_s, btn_press, qual, abort;
  logic [15:0] deb_cnt, cnt, cnt_nx;
  logic [1:0]  state_nx, cause_nx;
  sync2 u_btn_sync  (.clk, .rst_n, .d(ext_rst_n_i),  .q(btn_s));
  sync2 u_lock_sync (.clk, .rst_n, .d(pll_locked_i), .q(lock_s));
  assign btn_press = deb_cnt == DEB_MAX;
  assign qual      = lock_s && btn_s;
  always_comb begin
    abort    = (seq_state_o == ST_REL_PERIPH || seq_state_o == ST_RUN) &&
               (!lock_s || btn_press || (seq_state_o == ST_RUN && sw_rst_req_i));
    cause_nx = !lock_s ? CAUSE_LOCK : btn_press ? CAUSE_BTN : CAUSE_SW;
    state_nx = abort ? ST_HOLD :
               seq_state_o == ST_HOLD       ? (cnt == HOLD_LAST ? ST_WAIT_LOCK : ST_HOLD) :
               seq_state_o == ST_WAIT_LOCK  ? (qual && cnt == LOCK_LAST ? ST_REL_PERIPH : ST_WAIT_LOCK) :
               seq_state_o == ST_REL_PERIPH ? (cnt == GAP_LAST ? ST_RUN : ST_REL_PERIPH) : ST_RUN;
    cnt_nx   = (state_nx != seq_state_o || seq_state_o == ST_RUN ||
                (seq_state_o == ST_WAIT_LOCK && !qual)) ? 16'd0 : cnt + 16'd1;
  end
  // Output flops load from the next state so they track seq_state_o with no lag.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      seq_state_o    <= ST_HOLD;
      cnt            <= '0;
      deb_cnt        <= '0;
      rst_cause_o    <= CAUSE_POR;
      periph_rst_n_o <= 1'b0;
      core_rst_n_o   <= 1'b0;
    end else begin
      seq_state_o    <= state_nx;
      cnt            <= cnt_nx;
      deb_cnt        <= btn_s ? '0 : btn_press ? deb_cnt : deb_cnt + 16'd1;
      rst_cause_o    <= abort ? cause_nx : rst_cause_o;
      periph_rst_n_o <= state_nx == ST_REL_PERIPH || state_nx == ST_RUN;
      core_rst_n_o   <= state_nx == ST_RUN;
    end
endmodule

// File: tb/tb_soc_rst_sequencer.sv
// tb_soc_rst_sequencer: randomized and directed checks of the reset sequencer against a cycle-level behavioural model
module tb_soc_rst_sequencer;
  localparam int MH = 4, LC = 8, GC = 3, DC = 5;
  logic clk = 0, rst_n = 0, ext_rst_n_i = 1, pll_locked_i = 1, sw_rst_req_i = 0;
  logic periph_rst_n_o, core_rst_n_o;
  logic [1:0] seq_state_o, rst_cause_o;
  int checks = 0, passed = 0;
  int m_state = 0, m_cause = 0, m_n = 0, m_entry = 0, m_qual = 0, m_low = 0;
  logic [1:0] m_btn_p = 0, m_lock_p = 0;
  int f, rp, rc;
  always #5 clk = ~clk;
  soc_rst_sequencer #(.MIN_HOLD(MH), .LOCK_CYCLES(LC), .GAP_CYCLES(GC), .DEB_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .ext_rst_n_i(ext_rst_n_i), .pll_locked_i(pll_locked_i),
    .sw_rst_req_i(sw_rst_req_i), .periph_rst_n_o(periph_rst_n_o), .core_rst_n_o(core_rst_n_o),
    .seq_state_o(seq_state_o), .rst_cause_o(rst_cause_o));
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask
  // Model: phases timed by elapsed edges since phase entry, inputs seen through 2-edge delay lines.
  task automatic model_edge();
    bit bs, ls, pr, ab;
    int nx;
    if (!rst_n) begin
      m_state = 0; m_cause = 0; m_n = 0; m_entry = 0; m_qual = 0; m_low = 0;
      m_btn_p = 0; m_lock_p = 0;
    end else begin
      bs = m_btn_p[1]; ls = m_lock_p[1]; pr = m_low >= DC;
      m_n++;
      ab = m_state >= 2 && (!ls || pr || (m_state == 3 && sw_rst_req_i));
      nx = m_state;
      if (ab) begin
        nx = 0;
        m_cause = !ls ? 2 : pr ? 1 : 3;
      end else if (m_state == 0) begin
        if (m_n - m_entry == MH) nx = 1;
      end else if (m_state == 1) begin
        m_qual = (ls && bs) ? m_qual + 1 : 0;
        if (m_qual == LC) nx = 2;
      end else if (m_state == 2) begin
        if (m_n - m_entry == GC) nx = 3;
      end
      if (nx != m_state) begin m_entry = m_n; m_qual = 0; end
      m_state = nx;
      m_low = bs ? 0 : (m_low < DC ? m_low + 1 : DC);
      m_btn_p = {m_btn_p[0], ext_rst_n_i};
      m_lock_p = {m_lock_p[0], pll_locked_i};
    end
  endtask
  always @(posedge clk or negedge rst_n) model_edge();
  always @(negedge clk) begin
    chk("state", int'(seq_state_o), m_state);
    chk("periph", int'(periph_rst_n_o), int'(m_state >= 2));
    chk("core", int'(core_rst_n_o), int'(m_state == 3));
    chk("cause", int'(rst_cause_o), m_cause);
  end
  task automatic step();
    @(negedge clk); #2;
  endtask
  // Edge indices (from 1) of first periph-low edge, and of later periph/core rises.
  task automatic measure(input int lim, output int fall, output int rise_p, output int rise_c);
    fall = 0; rise_p = 0; rise_c = 0;
    for (int e = 1; e <= lim; e++) begin
      @(posedge clk); #1;
      if (fall == 0 && !periph_rst_n_o) fall = e;
      if (fall != 0 && e > fall && rise_p == 0 && periph_rst_n_o) rise_p = e;
      if (fall != 0 && e > fall && rise_c == 0 && core_rst_n_o) rise_c = e;
    end
  endtask
  initial begin
    int lk, bt, rs;
    repeat (3) step();
    chk("reset_state", int'(seq_state_o), 0);
    chk("reset_periph", int'(periph_rst_n_o), 0);
    chk("reset_cause", int'(rst_cause_o), 0);
    rst_n = 1;
    measure(20, f, rp, rc);
    chk("por_periph_edge", rp, 12);
    chk("por_core_edge", rc, 15);
    step(); pll_locked_i = 0;
    fork
      measure(30, f, rp, rc);
      begin step(); pll_locked_i = 1; end
    join
    chk("lock_fall_edge", f, 3);
    chk("lock_cause", int'(rst_cause_o), 2);
    chk("lock_reseq_periph", rp, 15);
    chk("lock_reseq_core", rc, 18);
    step(); ext_rst_n_i = 0;
    repeat (4) step();
    ext_rst_n_i = 1;
    repeat (10) step();
    chk("btn4_no_reset", int'(seq_state_o), 3);
    step(); ext_rst_n_i = 0;
    fork
      measure(30, f, rp, rc);
      begin repeat (6) step(); ext_rst_n_i = 1; end
    join
    chk("btn6_fall_edge", f, 8);
    chk("btn6_cause", int'(rst_cause_o), 1);
    chk("btn6_reseq_periph", rp, 20);
    repeat (5) step();
    ext_rst_n_i = 0;
    repeat (40) step();
    chk("btn_held_wait", int'(seq_state_o), 1);
    sw_rst_req_i = 1; step(); sw_rst_req_i = 0; step();
    chk("sw_in_wait_state", int'(seq_state_o), 1);
    chk("sw_in_wait_cause", int'(rst_cause_o), 1);
    ext_rst_n_i = 1;
    measure(20, f, rp, rc);
    chk("btn_release_periph", rp, 10);
    chk("btn_release_core", rc, 13);
    repeat (5) step();
    sw_rst_req_i = 1;
    @(posedge clk); #1;
    chk("sw_run_state", int'(seq_state_o), 0);
    chk("sw_run_core", int'(core_rst_n_o), 0);
    chk("sw_run_cause", int'(rst_cause_o), 3);
    step(); sw_rst_req_i = 0;
    repeat (20) step();
    ext_rst_n_i = 0;
    fork
      measure(12, f, rp, rc);
      begin repeat (5) step(); pll_locked_i = 0; step(); ext_rst_n_i = 1; end
    join
    chk("both_fall_edge", f, 8);
    chk("both_cause", int'(rst_cause_o), 2);
    step(); pll_locked_i = 1;
    for (int i = 0; i < 60 && seq_state_o != 2; i++) step();
    chk("reach_rel", int'(seq_state_o), 2);
    @(posedge clk); #2;
    rst_n = 0; #1;
    chk("async_periph", int'(periph_rst_n_o), 0);
    chk("async_state", int'(seq_state_o), 0);
    chk("async_cause", int'(rst_cause_o), 0);
    step(); rst_n = 1;
    measure(20, f, rp, rc);
    chk("rerst_periph_edge", rp, 12);
    chk("rerst_core_edge", rc, 15);
    lk = 0; bt = 0; rs = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (lk > 0) lk--; else if ($urandom_range(199) == 0) lk = $urandom_range(3, 1);
      if (bt > 0) bt--;
      else if ($urandom_range(119) == 0) bt = ($urandom_range(3) == 0) ? $urandom_range(40, 20) : $urandom_range(8, 1);
      if (rs > 0) rs--; else if ($urandom_range(999) == 0) rs = $urandom_range(2, 1);
      pll_locked_i = lk == 0;
      ext_rst_n_i = bt == 0;
      rst_n = rs == 0;
      sw_rst_req_i = $urandom_range(39) == 0;
    end
    step();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
